// File: rtl/dds_cmd_tx.sv
// DDS command bus transmitter: header nibble, then data nibbles MSB first.
// Define DDS_CMD_PARITY_EN to append an XOR parity nibble to each frame.
module dds_cmd_tx #(
   parameter int DATA_W  = 32,
   parameter int GAP_CYC = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_sel,
   input  logic [DATA_W-1:0] req_data,
   output logic [3:0]        cmd_out,
   output logic              cmd_hdr,
   output logic              cmd_dvld,
   output logic              busy,
   output logic              done
);

   localparam int NIB = DATA_W / 4;
   localparam int CW  = $clog2(NIB + 1);
   localparam int GW  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_GAP
`ifdef DDS_CMD_PARITY_EN
      , S_PAR
`endif
   } state_t;

   state_t            state_q, state_n;
   logic [DATA_W-1:0] sh_q, sh_n;
   logic [CW-1:0]     cnt_q, cnt_n;
   logic [GW-1:0]     gcnt_q, gcnt_n;
   logic [3:0]        out_n;
   logic              hdr_n, dvld_n, busy_n, done_n, rdy_n, fin;
`ifdef DDS_CMD_PARITY_EN
   logic [3:0]        par_q, par_n;
`endif

   always_comb begin
      state_n = state_q;
      sh_n    = sh_q;
      cnt_n   = cnt_q;
      gcnt_n  = gcnt_q;
      out_n   = 4'hF;
      hdr_n   = 1'b0;
      dvld_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      rdy_n   = 1'b0;
      fin     = 1'b0;
`ifdef DDS_CMD_PARITY_EN
      par_n   = par_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               state_n = S_HDR;
               sh_n    = req_data;
               cnt_n   = CW'(NIB);
               out_n   = {2'b00, req_sel};
               hdr_n   = 1'b1;
               busy_n  = 1'b1;
`ifdef DDS_CMD_PARITY_EN
               par_n   = {2'b00, req_sel};
`endif
            end else begin
               rdy_n = 1'b1;
            end
         end
         S_HDR, S_DATA: begin
            if (cnt_q != '0) begin
               state_n = S_DATA;
               out_n   = sh_q[DATA_W-1 -: 4];
               dvld_n  = 1'b1;
               busy_n  = 1'b1;
               sh_n    = sh_q << 4;
               cnt_n   = cnt_q - CW'(1);
`ifdef DDS_CMD_PARITY_EN
               par_n   = par_q ^ sh_q[DATA_W-1 -: 4];
`else
               done_n  = (cnt_q == CW'(1));
`endif
            end else begin
`ifdef DDS_CMD_PARITY_EN
               state_n = S_PAR;
               out_n   = par_q;
               dvld_n  = 1'b1;
               busy_n  = 1'b1;
               done_n  = 1'b1;
`else
               fin = 1'b1;
`endif
            end
         end
`ifdef DDS_CMD_PARITY_EN
         S_PAR: fin = 1'b1;
`endif
         S_GAP: begin
            if (gcnt_q != '0) begin
               busy_n = 1'b1;
               gcnt_n = gcnt_q - GW'(1);
            end else begin
               state_n = S_IDLE;
               rdy_n   = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
      // Frame tail: either enter the forced gap or return straight to idle
      if (fin) begin
         if (GAP_CYC > 0) begin
            state_n = S_GAP;
            busy_n  = 1'b1;
            gcnt_n  = GW'(GAP_CYC - 1);
         end else begin
            state_n = S_IDLE;
            rdy_n   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sh_q      <= '0;
         cnt_q     <= '0;
         gcnt_q    <= '0;
         cmd_out   <= 4'hF;
         cmd_hdr   <= 1'b0;
         cmd_dvld  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         req_ready <= 1'b0;
`ifdef DDS_CMD_PARITY_EN
         par_q     <= '0;
`endif
      end else begin
         state_q   <= state_n;
         sh_q      <= sh_n;
         cnt_q     <= cnt_n;
         gcnt_q    <= gcnt_n;
         cmd_out   <= out_n;
         cmd_hdr   <= hdr_n;
         cmd_dvld  <= dvld_n;
         busy      <= busy_n;
         done      <= done_n;
         req_ready <= rdy_n;
`ifdef DDS_CMD_PARITY_EN
         par_q     <= par_n;
`endif
      end
   end

endmodule
